// File: rtl/dmem_arb_pkg.sv
//==============================================================================
// Module   : dmem_arb_pkg
// Desc     : Shared types and width constants for the data-memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package dmem_arb_pkg;

  // Read-latency countdown width (RD_LATENCY is limited to 0..7)
  localparam int LAT_W = 3;

  // Starvation counter width (STARVE_LIMIT is limited to 1..255)
  localparam int STARVE_W = 8;

  // Debug-read sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
//==============================================================================
// Module   : dmem_arbiter_if
// Desc     : Bundles the core, debug and memory buses around the arbiter.
//            'slave' is the arbiter's view, 'master' is the environment's.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Core memory-stage side
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_rd;
  logic                  core_wr;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_stall;

  // Debug / LCD read side
  logic                  dbg_req;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic                  dbg_ack;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_valid;

  // Data-memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  core_addr, core_wdata, core_rd, core_wr,
    input  dbg_req, dbg_addr,
    input  mem_rdata,
    output core_rdata, core_stall,
    output dbg_ack, dbg_rdata, dbg_valid,
    output mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );

  modport master (
    output core_addr, core_wdata, core_rd, core_wr,
    output dbg_req, dbg_addr,
    output mem_rdata,
    input  core_rdata, core_stall,
    input  dbg_ack, dbg_rdata, dbg_valid,
    input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
//==============================================================================
// Module   : dmem_arb_starve_ctr
// Desc     : Counts cycles a pending debug read has been blocked by the core.
//            Saturates at 'limit'; at_limit flags that the core must yield.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  input  logic [STARVE_W-1:0] limit,
  output logic                at_limit
);

  logic [STARVE_W-1:0] cnt;

  // Clear has priority; increments stop once the limit is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Desc     : Shares one data-memory port between the core memory stage (high
//            priority) and a single-outstanding debug/LCD read port. Debug
//            reads slip into idle memory cycles; after STARVE_LIMIT blocked
//            cycles the core is stalled for exactly one cycle.
// Options  : DMEM_ARB_STATS_EN adds saturating stat_dbg_reads and
//            stat_stall_cycles counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]        stat_dbg_reads,
  output logic [15:0]        stat_stall_cycles
`endif
);

  localparam logic [LAT_W-1:0]    c_rd_latency   = LAT_W'(RD_LATENCY);
  localparam logic [STARVE_W-1:0] c_starve_limit = STARVE_W'(STARVE_LIMIT);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LAT_W-1:0]      lat_cnt;
  logic [LAT_W-1:0]      lat_cnt_nxt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  core_act;
  logic                  at_limit;
  logic                  issue;
  logic                  capture;
  logic                  accept;
  logic                  stall;

  assign core_act = bus.core_rd | bus.core_wr;
  assign issue    = (state == PEND) && (!core_act || at_limit);
  assign accept   = (state == IDLE) && bus.dbg_req;

  dmem_arb_starve_ctr u_starve (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .inc      ((state == PEND) && !issue),
    .limit    (c_starve_limit),
    .at_limit (at_limit)
  );

  // State, latency countdown and latched debug address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      addr_q  <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (accept) begin
        addr_q <= bus.dbg_addr;
      end
    end
  end

  // Debug read data holds until the next capture; reset discards it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Next-state and memory-port steering; core owns the port unless issuing
  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    capture       = 1'b0;
    stall         = 1'b0;
    bus.mem_addr  = bus.core_addr;
    bus.mem_wdata = bus.core_wdata;
    bus.mem_rd_en = bus.core_rd;
    bus.mem_wr_en = bus.core_wr;
    case (state)
      IDLE: begin
        if (bus.dbg_req) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (issue) begin
          bus.mem_addr  = addr_q;
          bus.mem_rd_en = 1'b1;
          bus.mem_wr_en = 1'b0;
          stall         = core_act;
          if (c_rd_latency == '0) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            lat_cnt_nxt = c_rd_latency;
            state_nxt   = WAIT;
          end
        end
      end
      WAIT: begin
        lat_cnt_nxt = lat_cnt - 1'b1;
        // A zero count cannot occur here; treat it as the last cycle anyway
        if (lat_cnt <= LAT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.core_rdata = bus.mem_rdata;
  assign bus.core_stall = stall;
  // Acknowledge is combinational, so it is masked while reset is held
  assign bus.dbg_ack    = accept & rst;
  assign bus.dbg_valid  = (state == DONE);
  assign bus.dbg_rdata  = rdata_q;

`ifdef DMEM_ARB_STATS_EN
  // Saturating counters of issued debug reads and core stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_dbg_reads    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (issue && (stat_dbg_reads != 16'hFFFF)) begin
        stat_dbg_reads <= stat_dbg_reads + 16'd1;
      end
      if (stall && (stat_stall_cycles != 16'hFFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module   : tb_dmem_arbiter
// Desc     : Directed self-checking bench for dmem_arbiter. Two instances:
//            u_dut1 (RD_LATENCY=1) and u_dut0 (RD_LATENCY=0), both with
//            STARVE_LIMIT=8, sharing one behavioural memory array.
// Options  : DMEM_ARB_STATS_EN also checks the statistics counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  int          n_tests;
  int          n_fail;

  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [0:255];
  logic [31:0] caddr;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] st1_reads, st1_stalls, st0_reads, st0_stalls;
`endif

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .STARVE_LIMIT(8)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_dbg_reads    (st1_reads),
    .stat_stall_cycles (st1_stalls)
`endif
  );

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(0), .STARVE_LIMIT(8)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_dbg_reads    (st0_reads),
    .stat_stall_cycles (st0_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: preload port, write from u_dut1, one-cycle registered read for u_dut1
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus1.mem_wr_en) begin
      mem[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
    if (bus1.mem_rd_en) begin
      bus1.mem_rdata <= mem[bus1.mem_addr[7:0]];
    end
  end

  // Combinational read for the zero-latency instance
  assign bus0.mem_rdata = mem[bus0.mem_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    cyc();
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    rst     = 1'b1;
    bus1.core_addr = '0; bus1.core_wdata = '0; bus1.core_rd = 1'b0; bus1.core_wr = 1'b0;
    bus1.dbg_req = 1'b0; bus1.dbg_addr = '0;
    bus0.core_addr = '0; bus0.core_wdata = '0; bus0.core_rd = 1'b0; bus0.core_wr = 1'b0;
    bus0.dbg_req = 1'b0; bus0.dbg_addr = '0;

    // ---------------- Reset: outputs quiet, memory follows the core ----------
    #2 rst = 1'b0;
    bus1.dbg_req    = 1'b1;
    bus1.dbg_addr   = 32'h40;
    bus1.core_rd    = 1'b1;
    bus1.core_addr  = 32'h99;
    bus1.core_wdata = 32'h77;
    #1;
    chk("rst_ack",      {31'd0, bus1.dbg_ack},    32'd0);
    chk("rst_stall",    {31'd0, bus1.core_stall}, 32'd0);
    chk("rst_valid",    {31'd0, bus1.dbg_valid},  32'd0);
    chk("rst_rdata",    bus1.dbg_rdata,           32'd0);
    chk("rst_mem_addr", bus1.mem_addr,            32'h99);
    chk("rst_mem_wd",   bus1.mem_wdata,           32'h77);
    chk("rst_mem_rd",   {31'd0, bus1.mem_rd_en},  32'd1);

    load(8'h40, 32'hCAFEF00D);
    load(8'h08, 32'h00000055);
    load(8'h10, 32'hA5A50010);
    load(8'h20, 32'h00000000);
    cyc();
    ld_en = 1'b0;
    bus1.dbg_req = 1'b0; bus1.core_rd = 1'b0; bus1.core_addr = '0; bus1.core_wdata = '0;
    cyc();
    rst = 1'b1;

    // ---------------- Idle core, debug read of 0x40 ---------------------------
    cyc(); bus1.dbg_req = 1'b1; bus1.dbg_addr = 32'h40; #1;
    chk("t1_ack",   {31'd0, bus1.dbg_ack},   32'd1);
    chk("t1_rd_c0", {31'd0, bus1.mem_rd_en}, 32'd0);
    cyc(); bus1.dbg_req = 1'b0; #1;
    chk("t1_issue_rd",   {31'd0, bus1.mem_rd_en},  32'd1);
    chk("t1_issue_addr", bus1.mem_addr,            32'h40);
    chk("t1_issue_stall",{31'd0, bus1.core_stall}, 32'd0);
    chk("t1_ack_c1",     {31'd0, bus1.dbg_ack},    32'd0);
    cyc(); #1;
    chk("t1_valid_c2",   {31'd0, bus1.dbg_valid},  32'd0);
    chk("t1_core_rdata", bus1.core_rdata,          32'hCAFEF00D);
    cyc(); #1;
    chk("t1_valid_c3",   {31'd0, bus1.dbg_valid},  32'd1);
    chk("t1_rdata",      bus1.dbg_rdata,           32'hCAFEF00D);
    chk("t1_stall_c3",   {31'd0, bus1.core_stall}, 32'd0);
    cyc(); #1;
    chk("t1_valid_c4",   {31'd0, bus1.dbg_valid},  32'd0);
    chk("t1_rdata_hold", bus1.dbg_rdata,           32'hCAFEF00D);

    // ---------------- Core reads every cycle: starvation stall ----------------
    cyc();
    caddr = 32'h80;
    bus1.core_rd = 1'b1; bus1.core_addr = caddr;
    bus1.dbg_req = 1'b1; bus1.dbg_addr = 32'h10; #1;
    chk("t2_ack",      {31'd0, bus1.dbg_ack}, 32'd1);
    chk("t2_addr_c0",  bus1.mem_addr,         32'h80);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      bus1.dbg_req = 1'b0;
      // The core holds its address for one cycle after the expected stall
      if (k != 10) caddr = caddr + 32'd1;
      bus1.core_addr = caddr;
      #1;
      chk($sformatf("t2_stall_k%0d", k), {31'd0, bus1.core_stall}, (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("t2_addr_k%0d", k),  bus1.mem_addr,            (k == 9) ? 32'h10 : caddr);
      chk($sformatf("t2_valid_k%0d", k), {31'd0, bus1.dbg_valid},  (k == 11) ? 32'd1 : 32'd0);
      if (k == 9) begin
        chk("t2_rd_en_k9", {31'd0, bus1.mem_rd_en}, 32'd1);
      end
      if (k == 10) begin
        chk("t2_represent", bus1.mem_addr, 32'h89);
      end
      if (k == 11) begin
        chk("t2_rdata", bus1.dbg_rdata, 32'hA5A50010);
      end
    end
    cyc(); bus1.core_rd = 1'b0; bus1.core_addr = '0;

    // ---------------- Write to 0x20 while a read of 0x20 is pending ---------
    cyc(); bus1.dbg_req = 1'b1; bus1.dbg_addr = 32'h20; #1;
    chk("t3_ack", {31'd0, bus1.dbg_ack}, 32'd1);
    cyc();
    bus1.dbg_req = 1'b0;
    bus1.core_wr = 1'b1; bus1.core_addr = 32'h20; bus1.core_wdata = 32'h1234; #1;
    chk("t3_wr_en",  {31'd0, bus1.mem_wr_en},  32'd1);
    chk("t3_wr_rd",  {31'd0, bus1.mem_rd_en},  32'd0);
    chk("t3_wr_dat", bus1.mem_wdata,           32'h1234);
    chk("t3_stall",  {31'd0, bus1.core_stall}, 32'd0);
    cyc(); bus1.core_wr = 1'b0; bus1.core_addr = '0; bus1.core_wdata = '0; #1;
    chk("t3_issue_rd",   {31'd0, bus1.mem_rd_en}, 32'd1);
    chk("t3_issue_addr", bus1.mem_addr,           32'h20);
    chk("t3_issue_wr",   {31'd0, bus1.mem_wr_en}, 32'd0);
    cyc(); #1;
    cyc(); #1;
    chk("t3_valid", {31'd0, bus1.dbg_valid}, 32'd1);
    chk("t3_rdata", bus1.dbg_rdata,          32'h1234);

`ifdef DMEM_ARB_STATS_EN
    // Three reads since reset, only the starved one stalled the core
    chk("st_reads",  {16'd0, st1_reads},  32'd3);
    chk("st_stalls", {16'd0, st1_stalls}, 32'd1);
`endif

    // ---------------- Zero-latency instance ----------------------------------
    cyc(); bus0.dbg_req = 1'b1; bus0.dbg_addr = 32'h08; #1;
    chk("t4_ack", {31'd0, bus0.dbg_ack}, 32'd1);
    cyc(); bus0.dbg_req = 1'b0; #1;
    chk("t4_issue_rd",   {31'd0, bus0.mem_rd_en}, 32'd1);
    chk("t4_issue_addr", bus0.mem_addr,           32'h08);
    chk("t4_valid_c1",   {31'd0, bus0.dbg_valid}, 32'd0);
    cyc(); #1;
    chk("t4_valid_c2",   {31'd0, bus0.dbg_valid}, 32'd1);
    chk("t4_rdata",      bus0.dbg_rdata,          32'h55);
    cyc(); #1;
    chk("t4_valid_c3",   {31'd0, bus0.dbg_valid}, 32'd0);

    // ---------------- Reset while a read is in WAIT --------------------------
    cyc(); bus1.dbg_req = 1'b1; bus1.dbg_addr = 32'h40; #1;
    chk("t5_ack", {31'd0, bus1.dbg_ack}, 32'd1);
    cyc(); bus1.dbg_req = 1'b0; #1;
    chk("t5_issue", {31'd0, bus1.mem_rd_en}, 32'd1);
    cyc(); #1;
    rst = 1'b0; #1;
    chk("t5_rst_rdata", bus1.dbg_rdata,           32'd0);
    chk("t5_rst_valid", {31'd0, bus1.dbg_valid},  32'd0);
    chk("t5_rst_stall", {31'd0, bus1.core_stall}, 32'd0);
    chk("t5_rst_rd",    {31'd0, bus1.mem_rd_en},  32'd0);
    cyc(); rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk($sformatf("t5_novalid_%0d", k), {31'd0, bus1.dbg_valid}, 32'd0);
      chk($sformatf("t5_nord_%0d", k),    {31'd0, bus1.mem_rd_en}, 32'd0);
    end
    cyc(); bus1.dbg_req = 1'b1; bus1.dbg_addr = 32'h08; #1;
    chk("t5_idle_ack", {31'd0, bus1.dbg_ack}, 32'd1);
    cyc(); bus1.dbg_req = 1'b0; #1;
    chk("t5_issue_addr", bus1.mem_addr, 32'h08);
    cyc(); #1;
    cyc(); #1;
    chk("t5_valid", {31'd0, bus1.dbg_valid}, 32'd1);
    chk("t5_rdata", bus1.dbg_rdata,          32'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core's memory stage and a debug/LCD read port.
- The core memory stage has priority; the debug/LCD read port is a low-priority, one-outstanding read requester.
- Sits between the execute result / memory-stage controls and the data memory.
- Inserts debug reads in idle memory cycles; a starvation limit forces a one-cycle core stall so the debug read is guaranteed to complete.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata (0 = combinational read); legal range 0..7
- STARVE_LIMIT, 8, cycles a pending debug read waits before the core is stalled; legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- core_addr  in  ADDR_WIDTH  core memory address (ALU result)
- core_wdata  in  DATA_WIDTH  core store data
- core_rd  in  1  core read enable
- core_wr  in  1  core write enable
- core_rdata  out  DATA_WIDTH  mem_rdata passed through combinationally
- core_stall  out  1  core must hold its request and freeze PC this cycle
- dbg_req  in  1  debug read request, level, held until dbg_ack
- dbg_addr  in  ADDR_WIDTH  debug read address, valid with dbg_req
- dbg_ack  out  1  one-cycle pulse: request latched
- dbg_rdata  out  DATA_WIDTH  registered debug read data
- dbg_valid  out  1  one-cycle pulse: dbg_rdata updated
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, lat_cnt=0, dbg_rdata=0, dbg_valid=0, dbg_ack=0, core_stall=0.
  - Memory outputs follow the core inputs during reset.
- FSM states: IDLE, PEND, WAIT, DONE.
- IDLE:
  - Memory is driven from the core.
  - If dbg_req=1: latch dbg_addr into addr_q, pulse dbg_ack, go to PEND, clear starve_cnt.
- PEND:
  - Issue condition: (core_rd|core_wr)=0, or starve_cnt==STARVE_LIMIT.
  - On issue: mem_addr=addr_q, mem_rd_en=1, mem_wr_en=0, core_stall=(core_rd|core_wr).
  - After issue: go to WAIT with lat_cnt=RD_LATENCY. If RD_LATENCY=0, capture mem_rdata in the issue cycle and go to DONE.
  - Otherwise: core passes through and starve_cnt increments.
- WAIT:
  - Core passes through; lat_cnt decrements.
  - Transition on lat_cnt==1: capture mem_rdata into dbg_rdata and go to DONE.
  - Net effect: capture happens exactly RD_LATENCY cycles after the issue edge.
- DONE: dbg_valid=1 for one cycle, then go to IDLE. A new dbg_req is honoured in the following IDLE cycle.
- dbg_rdata holds its value until the next capture.
- Only one debug read is outstanding at a time. dbg_req during PEND/WAIT/DONE is ignored (already acked).
- Core requests during WAIT proceed normally; memory is pipelined, and the core owns its own return data.
- core_rd and core_wr together is illegal; both are forwarded unchanged.
- core_stall is never asserted outside the PEND issue cycle: at most one stall per debug read.
- Reset mid-operation aborts any in-flight debug read: no dbg_valid, and dbg_rdata=0.
- starve_cnt is 8 bits and never exceeds STARVE_LIMIT.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With it: adds outputs stat_dbg_reads [15:0] (increments on every issue) and stat_stall_cycles [15:0] (increments when core_stall=1).
  - Both saturate at 16'hFFFF and are cleared by reset.
- Without it: these ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - FSM state encoding (IDLE=0, PEND=1, WAIT=2, DONE=3);
  - LAT_W=3 and STARVE_W=8 width constants.
- Sub-module dmem_arb_starve_ctr: starvation counter.
  - Inputs: clear, inc, limit.
  - Output: at_limit.
- Everything else stays in the top module.

Test Plan:
- Idle core, RD_LATENCY=1, mem[0x40]=0xCAFEF00D, dbg_req with dbg_addr=0x40:
  - cycle 0: dbg_ack; cycle 1: mem_rd_en with addr 0x40; cycle 3: dbg_valid with dbg_rdata=0xCAFEF00D;
  - core_stall stays 0.
- Core reads every cycle, STARVE_LIMIT=8, dbg_req with 0x10:
  - exactly one core_stall, 9 cycles after dbg_ack, with mem_addr=0x10;
  - the core request is re-presented next cycle and its address reaches memory.
- Core write to 0x20 (data 0x1234) in the same cycle a debug read to 0x20 is pending:
  - the write goes first; the debug read issues in the next idle cycle and returns 0x1234.
- RD_LATENCY=0: idle core, dbg_addr=0x8, mem[0x8]=0x55:
  - dbg_valid 2 cycles after dbg_ack, dbg_rdata=0x55.
- Assert rst=0 during WAIT:
  - outputs go to reset values immediately; no dbg_valid afterwards;
  - state is IDLE after rst=1.
- DMEM_ARB_STATS_EN with 3 debug reads, one of them starved:
  - stat_dbg_reads=3, stat_stall_cycles=1.
